conv_window_ctrl: RTL and testbench

//   Parametrised control path for the streaming convolver. Replaces the fixed
//   24/49-cycle enable with row/column tracking of an IMAGE_SIZE x IMAGE_SIZE frame.

---
 rtl/conv_ctrl_pkg.sv | 15 +
 rtl/conv_axis_counter.sv | 72 +++++++
 rtl/conv_window_ctrl.sv | 89 ++++++++
 tb/tb_conv_window_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the streaming convolver control path.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DONE   = 2'b10
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// One image axis: 0..MAX position counter with window membership and output index.
// CONV_STRIDE_EN adds a stride-phase counter so only every STRIDE-th position forms a window.
module conv_axis_counter
  import conv_ctrl_pkg::*;
#(
  parameter int MAX    = 27,
  parameter int OFFSET = 4,
  parameter int STRIDE = 1,
  parameter int W      = cnt_w(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic         wrap,
  output logic         in_win,
  output logic [W-1:0] idx
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] OFF_C = W'(OFFSET);

  if (STRIDE < 1 || OFFSET > MAX) begin : g_bad_param
    $error("conv_axis_counter: invalid parameters");
  end

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  assign wrap    = inc && (cnt == MAX_C);
  assign cnt_nxt = (cnt == MAX_C) ? '0 : cnt + W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt_nxt;
  end

`ifdef CONV_STRIDE_EN
  localparam int PW = cnt_w(STRIDE);
  localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);

  logic [PW-1:0] phase;

  // phase/idx describe cnt itself; both restart at the first in-window position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      idx   <= '0;
    end else if (clr) begin
      phase <= '0;
      idx   <= '0;
    end else if (inc) begin
      if (cnt_nxt <= OFF_C) begin
        phase <= '0;
        idx   <= '0;
      end else if (phase == PH_LAST) begin
        phase <= '0;
        idx   <= idx + W'(1);
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end

  assign in_win = (cnt >= OFF_C) && (phase == '0);
`else
  assign in_win = (cnt >= OFF_C);
  assign idx    = cnt - OFF_C;
`endif

endmodule

// File: rtl/conv_window_ctrl.sv
// Row/column tracking control path for an IMAGE_SIZE x IMAGE_SIZE streaming convolution.
// Optional strided windows via CONV_STRIDE_EN (handled inside conv_axis_counter).
//
//   state  | meaning
//   IDLE   | waiting for start, pix_ready low
//   STREAM | accepting pixels, tracking row/col
//   DONE   | one-cycle frame_done, pix_ready low
module conv_window_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter  int IMAGE_SIZE  = 28,
  parameter  int KERNEL_SIZE = 5,
  parameter  int STRIDE      = 1,
  localparam int CNT_W       = cnt_w(IMAGE_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             shift_en,
  output logic             win_valid,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             busy,
  output logic             frame_done
);

  if (KERNEL_SIZE < 1 || IMAGE_SIZE < KERNEL_SIZE || STRIDE < 1) begin : g_bad_param
    $error("conv_window_ctrl: invalid parameters");
  end

  state_t           state_q, state_d;
  logic             accept, clr;
  logic             col_wrap, row_wrap, col_in, row_in;
  logic [CNT_W-1:0] col_idx, row_idx;

  assign pix_ready  = (state_q == STREAM);
  assign accept     = pix_valid & pix_ready;
  assign shift_en   = accept;
  assign busy       = (state_q == STREAM) || (state_q == DONE);
  assign frame_done = (state_q == DONE);
  assign clr        = (state_q == IDLE) & start;

  conv_axis_counter #(
    .MAX(IMAGE_SIZE - 1), .OFFSET(KERNEL_SIZE - 1), .STRIDE(STRIDE), .W(CNT_W)
  ) u_col (
    .clk(clk), .reset(reset), .clr(clr), .inc(accept),
    .wrap(col_wrap), .in_win(col_in), .idx(col_idx)
  );

  // Row advances on the column wrap, so its wrap marks the last pixel of the frame
  conv_axis_counter #(
    .MAX(IMAGE_SIZE - 1), .OFFSET(KERNEL_SIZE - 1), .STRIDE(STRIDE), .W(CNT_W)
  ) u_row (
    .clk(clk), .reset(reset), .clr(clr), .inc(col_wrap),
    .wrap(row_wrap), .in_win(row_in), .idx(row_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (row_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      win_valid <= accept & row_in & col_in;
      if (accept & row_in & col_in) begin
        out_row <= row_idx;
        out_col <= col_idx;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed self-checking bench for conv_window_ctrl (main 28/5 instance plus 5/5 and 4/1 sweeps).
module tb_conv_window_ctrl;

  localparam int N  = 28;
  localparam int K  = 5;
  localparam int CW = 5;
`ifdef CONV_STRIDE_EN
  localparam int S       = 2;
  localparam int EXP_WIN = 144;
`else
  localparam int S       = 1;
  localparam int EXP_WIN = 576;
`endif

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic pix_ready, shift_en, win_valid, busy, frame_done;
  logic [CW-1:0] out_row, out_col;

  logic start_a = 1'b0, pv_a = 1'b0;
  logic ready_a, shift_a, wv_a, busy_a, fd_a;
  logic [2:0] row_a, col_a;

  logic start_b = 1'b0, pv_b = 1'b0;
  logic ready_b, shift_b, wv_b, busy_b, fd_b;
  logic [1:0] row_b, col_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMAGE_SIZE(N), .KERNEL_SIZE(K), .STRIDE(S)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .shift_en(shift_en), .win_valid(win_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .frame_done(frame_done)
  );

  conv_window_ctrl #(.IMAGE_SIZE(5), .KERNEL_SIZE(5), .STRIDE(1)) dut_k5n5 (
    .clk(clk), .reset(reset), .start(start_a), .pix_valid(pv_a),
    .pix_ready(ready_a), .shift_en(shift_a), .win_valid(wv_a),
    .out_row(row_a), .out_col(col_a), .busy(busy_a), .frame_done(fd_a)
  );

  conv_window_ctrl #(.IMAGE_SIZE(4), .KERNEL_SIZE(1), .STRIDE(1)) dut_k1n4 (
    .clk(clk), .reset(reset), .start(start_b), .pix_valid(pv_b),
    .pix_ready(ready_b), .shift_en(shift_b), .win_valid(wv_b),
    .out_row(row_b), .out_col(col_b), .busy(busy_b), .frame_done(fd_b)
  );

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; pix_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pix_ready, shift_en, win_valid, busy, frame_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {pix_ready, shift_en, win_valid, busy, frame_done});
    end
    checks++;
    if (out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL reset_coords got (%0d,%0d) want (0,0)", out_row, out_col);
    end
    checks++;
    if ({ready_a, wv_a, busy_a, fd_a, ready_b, wv_b, busy_b, fd_b} !== 8'b0) begin
      errors++;
      $display("FAIL reset_sweep_duts got %b want 00000000", {ready_a, wv_a, busy_a, fd_a, ready_b, wv_b, busy_b, fd_b});
    end
    start = 1'b0; pix_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b pix_ready=%b want 0 0", busy, pix_ready);
    end
  endtask

  // Starts a frame and feeds npix pixels; every cycle is checked against a pixel-order model.
  task automatic stream_frame(input int gap_pct, input int npix, input bit rand_start, output int nwin);
    int pix = 0;
    int cyc = 0;
    int r, c;
    bit acc, exp_wv;
    logic [CW-1:0] er, ec;
    nwin = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (pix < npix && cyc < 20000) begin
      pix_valid = ($urandom_range(0, 99) >= gap_pct);
      if (rand_start) start = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (pix_ready !== 1'b1 || shift_en !== pix_valid) begin
        errors++;
        $display("FAIL handshake pix=%0d pix_ready=%b shift_en=%b want 1 %b", pix, pix_ready, shift_en, pix_valid);
      end
      acc = pix_valid;
      @(posedge clk);
      #1;
      cyc++;
      r = pix / N;
      c = pix % N;
      exp_wv = acc && r >= K - 1 && c >= K - 1 && ((r - K + 1) % S) == 0 && ((c - K + 1) % S) == 0;
      checks++;
      if (win_valid !== exp_wv) begin
        errors++;
        $display("FAIL win_valid pix=(%0d,%0d) acc=%b got %b want %b", r, c, acc, win_valid, exp_wv);
      end
      if (exp_wv) begin
        nwin++;
        er = CW'((r - K + 1) / S);
        ec = CW'((c - K + 1) / S);
        checks++;
        if (out_row !== er || out_col !== ec) begin
          errors++;
          $display("FAIL window_coords got (%0d,%0d) want (%0d,%0d)", out_row, out_col, er, ec);
        end
      end
      checks++;
      if (frame_done !== (acc && pix == N * N - 1)) begin
        errors++;
        $display("FAIL frame_done pix=%0d got %b want %b", pix, frame_done, (acc && pix == N * N - 1));
      end
      if (acc) pix++;
    end
    pix_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (pix < npix) begin
      errors++;
      $display("FAIL stream_timeout accepted %0d want %0d", pix, npix);
    end
    if (npix == N * N) begin
      checks++;
      if (pix_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL done_state pix_ready=%b busy=%b want 0 1", pix_ready, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({pix_ready, busy, frame_done, win_valid} !== 4'b0) begin
        errors++;
        $display("FAIL idle_after_frame got %b want 0000", {pix_ready, busy, frame_done, win_valid});
      end
    end
  endtask

  task automatic test_main_frame();
    int nwin;
    stream_frame(0, N * N, 1'b0, nwin);
    checks++;
    if (nwin != EXP_WIN) begin
      errors++;
      $display("FAIL window_count_full got %0d want %0d", nwin, EXP_WIN);
    end
  endtask

  task automatic test_stall();
    int nwin;
    stream_frame(50, N * N, 1'b1, nwin);
    checks++;
    if (nwin != EXP_WIN) begin
      errors++;
      $display("FAIL window_count_stall got %0d want %0d", nwin, EXP_WIN);
    end
  endtask

  task automatic test_abort();
    int nwin;
    stream_frame(0, 300, 1'b0, nwin);
    pix_valid = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({pix_ready, shift_en, win_valid, busy, frame_done} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_ctrl got %b want 00000", {pix_ready, shift_en, win_valid, busy, frame_done});
    end
    checks++;
    if (out_row !== '0 || out_col !== '0) begin
      errors++;
      $display("FAIL async_reset_coords got (%0d,%0d) want (0,0)", out_row, out_col);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_frame_done cycle=%0d got %b want 0", i, frame_done);
      end
    end
    pix_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    stream_frame(0, N * N, 1'b0, nwin);
    checks++;
    if (nwin != EXP_WIN) begin
      errors++;
      $display("FAIL window_count_after_abort got %0d want %0d", nwin, EXP_WIN);
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt = 0;
    int cyc = 0;
    int last_fd = 0;
    start = 1'b1;
    pix_valid = 1'b1;
    while (fd_cnt < 2 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        checks++;
        if (pix_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_in_done frame=%0d got %b want 0", fd_cnt, pix_ready);
        end
        if (fd_cnt == 2) begin
          start = 1'b0;
          checks++;
          if (cyc - last_fd != N * N + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d", cyc - last_fd, N * N + 2);
          end
        end
        last_fd = cyc;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if ({pix_ready, busy, frame_done} !== 3'b0) begin
          errors++;
          $display("FAIL b2b_idle_gap frame=%0d got %b want 000", fd_cnt, {pix_ready, busy, frame_done});
        end
      end
    end
    pix_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (fd_cnt != 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", fd_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stays_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_param_sweep();
    int n = 0;
    int cyc = 0;
    bit seen_fd = 1'b0;
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    pv_a = 1'b1;
    while (!seen_fd && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wv_a) begin
        n++;
        checks++;
        if (row_a !== 3'd0 || col_a !== 3'd0) begin
          errors++;
          $display("FAIL k5n5_coords got (%0d,%0d) want (0,0)", row_a, col_a);
        end
      end
      if (fd_a) begin
        seen_fd = 1'b1;
        checks++;
        if (wv_a !== 1'b1) begin
          errors++;
          $display("FAIL k5n5_window_with_done got %b want 1", wv_a);
        end
      end
    end
    pv_a = 1'b0;
    checks++;
    if (!seen_fd || n != 1 || cyc != 25) begin
      errors++;
      $display("FAIL k5n5_summary done=%b windows=%0d cycles=%0d want 1 1 25", seen_fd, n, cyc);
    end

    n = 0; cyc = 0; seen_fd = 1'b0;
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    pv_b = 1'b1;
    while (!seen_fd && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wv_b) begin
        checks++;
        if (row_b !== 2'(n / 4) || col_b !== 2'(n % 4)) begin
          errors++;
          $display("FAIL k1n4_coords idx=%0d got (%0d,%0d) want (%0d,%0d)", n, row_b, col_b, n / 4, n % 4);
        end
        n++;
      end
      if (fd_b) seen_fd = 1'b1;
    end
    pv_b = 1'b0;
    checks++;
    if (!seen_fd || n != 16 || cyc != 16) begin
      errors++;
      $display("FAIL k1n4_summary done=%b windows=%0d cycles=%0d want 1 16 16", seen_fd, n, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_main_frame();
    test_stall();
    test_abort();
    test_back_to_back();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
